// File: rtl/id_stage_pipe.sv
// Decode stage: instruction decode, 16-entry register file with WB bypass,
// load-use interlock and the ID/EX pipeline register.
module id_stage_pipe #(
  parameter int DATA_W    = 16,
  parameter int BYPASS_EN = 1,
  parameter int HAZARD_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  input  logic [15:0]       instr,
  input  logic [DATA_W-1:0] pc_inc,
  input  logic              stall_in,
  input  logic              flush,
  input  logic              wb_we,
  input  logic [3:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              id_stall,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_pc_inc,
  output logic [DATA_W-1:0] ex_r0,
  output logic [DATA_W-1:0] ex_r1,
  output logic [DATA_W-1:0] ex_imm,
  output logic [DATA_W-1:0] ex_offset,
  output logic [DATA_W-1:0] ex_pccall,
  output logic              ex_call,
  output logic [3:0]        ex_rs,
  output logic [3:0]        ex_rt,
  output logic [3:0]        ex_rd,
  output logic [3:0]        ex_dst,
  output logic [2:0]        ex_bcond,
  output logic [7:0]        ex_ctrl_ex,
  output logic [2:0]        ex_ctrl_m,
  output logic [2:0]        ex_ctrl_wb
);

  logic [3:0] opc, rd, rs, rt;
  logic [3:0] addr0, addr1, dst;
  logic       use0, use1;
  logic       reg_write, mem_read, mem_write, mem_to_reg, branch, ret, call;
  logic       pc_to_mem, sp_addr;
  logic [1:0] alu_src;
  logic [3:0] alu_op;

  // An empty fetch slot decodes exactly like the no-op opcode.
  assign opc = if_valid ? instr[15:12] : 4'hF;
  assign rd  = instr[11:8];
  assign rs  = instr[7:4];
  assign rt  = instr[3:0];

  always_comb begin
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    branch     = 1'b0;
    ret        = 1'b0;
    call       = 1'b0;
    pc_to_mem  = 1'b0;
    sp_addr    = 1'b0;
    alu_src    = 2'b00;
    alu_op     = 4'h0;
    addr0      = rs;
    addr1      = rt;
    use0       = 1'b1;
    use1       = 1'b0;
    case (opc)
      4'h0, 4'h1, 4'h2, 4'h3: begin
        reg_write = 1'b1;
        alu_op    = opc;
        use1      = 1'b1;
      end
      4'h4: begin
        reg_write = 1'b1;
        alu_src   = 2'b01;
      end
      4'h5, 4'h6, 4'h7: begin
        reg_write = 1'b1;
        alu_src   = 2'b01;
        alu_op    = opc;
      end
      4'h8: begin
        reg_write  = 1'b1;
        mem_read   = 1'b1;
        mem_to_reg = 1'b1;
        alu_src    = 2'b01;
        addr0      = 4'hE;
      end
      4'h9: begin
        mem_write = 1'b1;
        alu_src   = 2'b01;
        addr0     = 4'hE;
        addr1     = rd;
        use1      = 1'b1;
      end
      4'hA, 4'hB: begin
        reg_write = 1'b1;
        alu_src   = 2'b10;
        alu_op    = opc;
        addr0     = rd;
      end
      4'hC: begin
        branch = 1'b1;
        use0   = 1'b0;
      end
      4'hD: begin
        reg_write = 1'b1;
        mem_write = 1'b1;
        pc_to_mem = 1'b1;
        sp_addr   = 1'b1;
        call      = 1'b1;
        alu_src   = 2'b11;
        alu_op    = 4'h1;
        addr0     = 4'hF;
      end
      4'hE: begin
        reg_write = 1'b1;
        mem_read  = 1'b1;
        ret       = 1'b1;
        alu_src   = 2'b11;
        addr0     = 4'hF;
      end
      default: use0 = 1'b0;
    endcase
  end

  assign dst = (opc == 4'hD || opc == 4'hE) ? 4'hF : rd;

  logic [DATA_W-1:0] rf [16];
  logic [DATA_W-1:0] rd_data0, rd_data1;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) rf[i] <= '0;
    end else if (wb_we && wb_addr != 4'h0) begin
      rf[wb_addr] <= wb_data;
    end
  end

  function automatic logic [DATA_W-1:0] rf_read(input logic [3:0] a);
    if (a == 4'h0)
      return '0;
    else if (BYPASS_EN != 0 && wb_we && a == wb_addr)
      return wb_data;
    else
      return rf[a];
  endfunction

  always_comb begin
    rd_data0 = rf_read(addr0);
    rd_data1 = rf_read(addr1);
  end

  // MemToReg separates LW from RET, which also sets MemRead.
  logic hazard_hit;
  assign hazard_hit = ex_valid && ex_ctrl_m[0] && ex_ctrl_wb[0] && (ex_dst != 4'h0) &&
                      ((use0 && addr0 == ex_dst) || (use1 && addr1 == ex_dst));
  assign id_stall   = (HAZARD_EN != 0) && hazard_hit && !flush && !rst;

  // Bubbles only clear valid and control; datapath fields keep old values.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid   <= 1'b0;
      ex_pc_inc  <= '0;
      ex_r0      <= '0;
      ex_r1      <= '0;
      ex_imm     <= '0;
      ex_offset  <= '0;
      ex_pccall  <= '0;
      ex_call    <= 1'b0;
      ex_rs      <= 4'h0;
      ex_rt      <= 4'h0;
      ex_rd      <= 4'h0;
      ex_dst     <= 4'h0;
      ex_bcond   <= 3'h0;
      ex_ctrl_ex <= 8'h00;
      ex_ctrl_m  <= 3'h0;
      ex_ctrl_wb <= 3'h0;
    end else if (flush || (!stall_in && id_stall)) begin
      ex_valid   <= 1'b0;
      ex_call    <= 1'b0;
      ex_ctrl_ex <= 8'h00;
      ex_ctrl_m  <= 3'h0;
      ex_ctrl_wb <= 3'h0;
    end else if (!stall_in) begin
      ex_valid   <= if_valid;
      ex_pc_inc  <= pc_inc;
      ex_r0      <= rd_data0;
      ex_r1      <= rd_data1;
      ex_imm     <= {{(DATA_W-4){instr[3]}}, instr[3:0]};
      ex_offset  <= {{(DATA_W-8){instr[7]}}, instr[7:0]};
      ex_pccall  <= {pc_inc[DATA_W-1:12], instr[11:0]};
      ex_call    <= call;
      ex_rs      <= rs;
      ex_rt      <= rt;
      ex_rd      <= rd;
      ex_dst     <= dst;
      ex_bcond   <= instr[10:8];
      ex_ctrl_ex <= {sp_addr, pc_to_mem, alu_src, alu_op};
      ex_ctrl_m  <= {branch, mem_write, mem_read};
      ex_ctrl_wb <= {reg_write, ret, mem_to_reg};
    end
  end

endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
- Parametrised decode stage for the 5-stage pipelined CPU.
- Decodes the 16-bit instruction and reads a 16-entry register file with write-through bypass from WB.
- Detects load-use hazards and owns the ID/EX pipeline register, which supports stall, bubble and flush.
- Datapath width is a parameter; the instruction format stays 16 bits.

Parameters:
- DATA_W, 16: register, PC and immediate width; must be >= 16.
- BYPASS_EN, 1: 1 = a WB write is visible to a same-cycle ID read.
- HAZARD_EN, 1: 1 = load-use interlock enabled; 0 = id_stall is tied to 0.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- if_valid  in  1  instr/pc_inc hold a real instruction
- instr  in  16  fetched instruction
- pc_inc  in  DATA_W  PC+1 of instr
- stall_in  in  1  downstream hold; ID/EX keeps its contents
- flush  in  1  taken branch/call/ret; squash the instruction in ID
- wb_we  in  1  register write enable
- wb_addr  in  4  register write address
- wb_data  in  DATA_W  register write data
- id_stall  out  1  load-use hazard; IF must hold PC and instr
- ex_valid  out  1  ID/EX holds a real instruction
- ex_pc_inc  out  DATA_W  registered pc_inc
- ex_r0, ex_r1  out  DATA_W  registered port-0/port-1 read data
- ex_imm  out  DATA_W  sign-extended instr[3:0]
- ex_offset  out  DATA_W  sign-extended instr[7:0]
- ex_pccall  out  DATA_W  {pc_inc[DATA_W-1:12], instr[11:0]}
- ex_call  out  1  CALL decoded
- ex_rs, ex_rt, ex_rd  out  4  instr[7:4], [3:0], [11:8]
- ex_dst  out  4  write address (F for CALL/RET, else rd)
- ex_bcond  out  3  instr[10:8]
- ex_ctrl_ex  out  8  {SPAddr, PCToMem, ALUSrc[1:0], ALUOp[3:0]}
- ex_ctrl_m  out  3  {Branch, MemWrite, MemRead}
- ex_ctrl_wb  out  3  {RegWrite, Ret, MemToReg}

Behaviour:
- Decode table (opcode -> asserted controls):
  - 0-3 ADD/SUB/NAND/XOR: RegWrite; ALUOp=opcode.
  - 4 INC: RegWrite; ALUSrc=01; ALUOp=0.
  - 5-7 shifts: RegWrite; ALUSrc=01; ALUOp=opcode.
  - 8 LW: RegWrite, MemRead, MemToReg; ALUSrc=01; port0 addr=E.
  - 9 SW: MemWrite; ALUSrc=01; port0 addr=E; port1 addr=rd.
  - A/B LHB/LLB: RegWrite; ALUSrc=10; ALUOp=opcode; port0 addr=rd.
  - C B: Branch; no register reads.
  - D CALL: RegWrite, MemWrite, PCToMem, SPAddr, Call; ALUSrc=11; ALUOp=1; port0 addr=F.
  - E RET: RegWrite, MemRead, Ret; ALUSrc=11; ALUOp=0; port0 addr=F.
  - F: no-op, all controls 0.
  - Otherwise port0 addr=rs, port1 addr=rt. Port-use flags: port1 is used only by 0-3 and SW; port0 by every opcode except B and F.
  - if_valid=0 decodes as opcode F.
- Register file: 16 x DATA_W.
  - Register 0 reads as 0; writes to it are ignored.
  - Write occurs on the clk edge when wb_we=1.
  - BYPASS_EN=1: a read of addr==wb_addr!=0 while wb_we=1 returns wb_data combinationally.
  - rst clears all entries to 0 synchronously.
- Hazard: id_stall=1 when all of the following hold:
  - HAZARD_EN=1, ex_valid=1, ex_ctrl_m[0] (MemRead)=1, ex_ctrl_ex[4]... more precisely ex opcode is LW (MemToReg=1), ex_dst!=0;
  - a used port address of the ID instruction equals ex_dst;
  - flush=0.
  - id_stall is combinational, and is 0 during reset.
- ID/EX update on each clk edge, in priority order:
  1. rst: all ex_* = 0.
  2. flush: bubble (ex_valid=0, all ctrl=0).
  3. stall_in: hold all ex_* unchanged.
  4. id_stall: bubble.
  5. Otherwise: load decoded values; ex_valid=if_valid.
- Latency: 1 cycle from instr to ex_*. The datapath fields of a bubble are don't-care, but ctrl must be 0.
- stall_in and id_stall together: hold wins; id_stall stays asserted until ID/EX advances.
- Reset asserted mid-stall clears everything; id_stall=0 on the following cycle.

Test Plan:
- Reset, then ADD R3,R1,R2 with R1=5, R2=7 preloaded via WB -> next cycle ex_r0=5, ex_r1=7, ex_ctrl_wb=3'b100, ex_ctrl_ex=8'h00, ex_valid=1.
- Bypass: wb_we=1, wb_addr=4, wb_data=16'hBEEF in the same cycle ID decodes XOR R5,R4,R0 -> ex_r0=BEEF, ex_r1=0. With BYPASS_EN=0 -> ex_r0 = old R4.
- Load-use: LW R6,[E+2] followed by ADD R7,R6,R1 -> id_stall=1 for one cycle, one bubble with ex_valid=0, then ADD loads. ADD R7,R1,R2 after the LW -> no stall.
- CALL 0x123 with pc_inc=16'h4008 -> ex_pccall=16'h4123, ex_call=1, ex_dst=F, ex_ctrl_ex=8'hF1.
- Flush and stall_in asserted in the same cycle -> bubble loaded. stall_in alone for 3 cycles -> ex_* unchanged throughout.
- Immediates: instr 16'h54FC (SRA) -> ex_imm=16'hFFFC. instr 16'h8E80 -> ex_offset=16'hFF80. Repeat with DATA_W=32 -> 32'hFFFFFFFC and 32'hFFFFFF80.
